// File: rtl/sccb_pkg.sv
// sccb_pkg: shared constants for the SCCB responder.
// State codes, default device ID and bit-counter width.
package sccb_pkg;

  localparam logic [7:0] DEV_ID_DEF = 8'h42;
  localparam int         BCNT_W     = 4;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ID       = 4'd1;
  localparam logic [3:0] ST_ID_ACK   = 4'd2;
  localparam logic [3:0] ST_SUB      = 4'd3;
  localparam logic [3:0] ST_SUB_ACK  = 4'd4;
  localparam logic [3:0] ST_WDAT     = 4'd5;
  localparam logic [3:0] ST_WDAT_ACK = 4'd6;
  localparam logic [3:0] ST_RDAT     = 4'd7;
  localparam logic [3:0] ST_RDAT_NA  = 4'd8;
  localparam logic [3:0] ST_IGNORE   = 4'd9;

endpackage

// File: rtl/sccb_sync_edge.sv
// sccb_sync_edge: multi-flop synchroniser for one bus input,
// with single-cycle rise/fall pulses on the synchronised level.
module sccb_sync_edge
  import sccb_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB camera-side target with a register-port handshake.
// Build option SCCB_ACK_EN: drive sdl low during ID/SUB/WDAT ACK slots.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = DEV_ID_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sccb_e,
  inout  wire        sdl_wire,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_lvl_unused, scl_rise, scl_fall;
  logic e_lvl, e_rise, e_fall;
  logic sdl_lvl, sdl_rise_unused, sdl_fall_unused;

  sccb_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl (
    .clk   (sys_clk),
    .rst   (rst),
    .din   (scl),
    .level (scl_lvl_unused),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  sccb_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_e (
    .clk   (sys_clk),
    .rst   (rst),
    .din   (sccb_e),
    .level (e_lvl),
    .rise  (e_rise),
    .fall  (e_fall)
  );

  sccb_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sdl (
    .clk   (sys_clk),
    .rst   (rst),
    .din   (sdl_wire),
    .level (sdl_lvl),
    .rise  (sdl_rise_unused),
    .fall  (sdl_fall_unused)
  );

  logic [3:0]        state_q, state_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              cap_q, cap_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              oe_q, oe_d;
  logic              sdo_q, sdo_d;

  logic [7:0] rx_byte;
  logic       last_bit;

  assign rx_byte  = {rx_q, sdl_lvl};
  assign last_bit = (bit_cnt_q == BCNT_W'(7));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    cap_d     = re_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    oe_d      = oe_q;
    sdo_d     = sdo_q;

    // bank answers the cycle after reg_re; take it one cycle later
    if (cap_q) tx_d = reg_rdata;

    if (e_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
      oe_d      = 1'b0;
    end else if (e_fall) begin
      state_d   = ST_ID;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
      oe_d      = 1'b0;
    end else if (!e_lvl && scl_rise) begin
      case (state_q)
        ST_ID: begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (last_bit) begin
            bit_cnt_d = '0;
            rw_d      = rx_byte[0];
            if (rx_byte[7:1] == DEV_ID[7:1]) begin
              state_d = ST_ID_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ID_ACK: begin
          bit_cnt_d = '0;
          if (rw_q) begin
            re_d    = 1'b1;
            state_d = ST_RDAT;
          end else begin
            state_d = ST_SUB;
          end
        end
        ST_SUB: begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (last_bit) begin
            bit_cnt_d = '0;
            addr_d    = rx_byte;
            state_d   = ST_SUB_ACK;
          end
        end
        ST_SUB_ACK: state_d = ST_WDAT;
        ST_WDAT: begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (last_bit) begin
            bit_cnt_d = '0;
            wdata_d   = rx_byte;
            we_d      = 1'b1;
            state_d   = ST_WDAT_ACK;
          end
        end
        ST_WDAT_ACK: begin
          addr_d  = addr_q + 8'd1;
          state_d = ST_WDAT;
        end
        ST_RDAT: begin
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (last_bit) begin
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            state_d   = ST_RDAT_NA;
          end
        end
        ST_RDAT_NA: begin
          addr_d  = addr_q + 8'd1;
          re_d    = 1'b1;
          state_d = ST_RDAT;
        end
        default: ;
      endcase
    end else if (!e_lvl && scl_fall) begin
      oe_d = 1'b0;
      if (state_q == ST_RDAT) begin
        oe_d  = 1'b1;
        sdo_d = tx_q[7];
        tx_d  = {tx_q[6:0], 1'b0};
      end
`ifdef SCCB_ACK_EN
      else if (state_q == ST_ID_ACK || state_q == ST_SUB_ACK ||
               state_q == ST_WDAT_ACK) begin
        oe_d  = 1'b1;
        sdo_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      cap_q     <= 1'b0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      oe_q      <= 1'b0;
      sdo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      cap_q     <= cap_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      oe_q      <= oe_d;
      sdo_q     <= sdo_d;
    end
  end

  assign sdl_wire  = oe_q ? sdo_q : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;

endmodule
